// File: rtl/inst_fetch_axi_master.sv
// Instruction fetch engine: copies num_words words from AXI host memory into imem via single-outstanding INCR bursts.
// Latency: one AR per burst of up to MAX_BURST beats; each accepted R beat is written to imem in the same cycle.
// Backpressure: AR fields held until m_arready; m_rready is high throughout RD_DATA, so R stalls come only from m_rvalid.
module inst_fetch_axi_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int BURST_WIDTH     = 8,
    parameter int MAX_BURST       = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AXI_ADDR_WIDTH-1:0]  base_addr,
    input  logic [CNT_WIDTH-1:0]       num_words,
    input  logic [IMEM_ADDR_WIDTH-1:0] imem_base,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       imem_wr_req,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0]      imem_wr_data,
    output logic [AXI_ADDR_WIDTH-1:0]  m_araddr,
    output logic [BURST_WIDTH-1:0]     m_arlen,
    output logic [2:0]                 m_arsize,
    output logic [1:0]                 m_arburst,
    output logic                       m_arvalid,
    input  logic                       m_arready,
    input  logic [DATA_WIDTH-1:0]      m_rdata,
    input  logic [1:0]                 m_rresp,
    input  logic                       m_rlast,
    input  logic                       m_rvalid,
    output logic                       m_rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam int BW    = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, DONE} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 rst_sync_q;
    logic                       run_en;
    logic [AXI_ADDR_WIDTH-1:0]  araddr_q;
    logic [CNT_WIDTH-1:0]       remaining_q;
    logic [IMEM_ADDR_WIDTH-1:0] imem_ptr_q;
    logic [BW-1:0]              beat_cnt_q, burst_len_q, burst_len;
    logic                       error_q;
    logic                       start_acc, ar_hs, r_beat, last_beat;
    logic [12:0]                bytes_to_4k, words_to_4k;
    logic [31:0]                len_calc;

    // Deassertion of reset is only trusted once it has crossed two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run_en = rst_sync_q[1];

    assign start_acc = (state_q == IDLE) && start && run_en;
    assign ar_hs     = (state_q == RD_ADDR) && m_arready;
    assign r_beat    = (state_q == RD_DATA) && m_rvalid;
    assign last_beat = r_beat && ((beat_cnt_q + BW'(1)) == burst_len_q);

    // Burst never runs past the 4 KB page holding the current address.
    assign bytes_to_4k = 13'h1000 - {1'b0, araddr_q[11:0]};
    assign words_to_4k = bytes_to_4k >> SIZE;

    always_comb begin
        len_calc = 32'(remaining_q);
        if (len_calc > 32'(MAX_BURST)) len_calc = 32'(MAX_BURST);
        if (len_calc > 32'(words_to_4k)) len_calc = 32'(words_to_4k);
    end
    assign burst_len = BW'(len_calc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = (num_words == '0) ? DONE : RD_ADDR;
            RD_ADDR: if (ar_hs) state_d = RD_DATA;
            RD_DATA: if (last_beat) state_d = (remaining_q == CNT_WIDTH'(1)) ? DONE : RD_ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        m_arvalid    = (state_q == RD_ADDR);
        m_rready     = (state_q == RD_DATA);
        m_araddr     = araddr_q;
        m_arlen      = m_arvalid ? BURST_WIDTH'(len_calc - 32'd1) : '0;
        m_arsize     = 3'(SIZE);
        m_arburst    = 2'b01;
        imem_wr_req  = r_beat;
        imem_wr_addr = imem_ptr_q;
        imem_wr_data = r_beat ? m_rdata : '0;
        error        = error_q;
    end

    // rlast is only cross-checked against the internal beat count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            araddr_q    <= '0;
            remaining_q <= '0;
            imem_ptr_q  <= '0;
            beat_cnt_q  <= '0;
            burst_len_q <= '0;
            error_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                araddr_q    <= base_addr;
                remaining_q <= num_words;
                imem_ptr_q  <= imem_base;
                error_q     <= 1'b0;
            end
            if (ar_hs) begin
                burst_len_q <= burst_len;
                beat_cnt_q  <= '0;
            end
            if (r_beat) begin
                imem_ptr_q  <= imem_ptr_q + IMEM_ADDR_WIDTH'(1);
                remaining_q <= remaining_q - CNT_WIDTH'(1);
                araddr_q    <= araddr_q + AXI_ADDR_WIDTH'(BYTES);
                beat_cnt_q  <= beat_cnt_q + BW'(1);
                if ((m_rresp != 2'b00) || (last_beat != m_rlast)) error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi_master.sv
// Bench for inst_fetch_axi_master: AXI slave model plus queue-based expectation of ARs and imem writes.
module tb_inst_fetch_axi_master;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic [9:0]  imem_base;
    logic        busy, done, error, imem_wr_req;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data, m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    always #5 clk = ~clk;

    inst_fetch_axi_master #(
        .DATA_WIDTH(32), .IMEM_ADDR_WIDTH(10), .AXI_ADDR_WIDTH(32),
        .BURST_WIDTH(8), .MAX_BURST(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .imem_base(imem_base), .busy(busy), .done(done),
        .error(error), .imem_wr_req(imem_wr_req), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ar_addr[$], exp_ar_len[$], exp_wr_addr[$], exp_wr_data[$];
    logic [31:0] log_ar_addr[$], log_ar_len[$];
    logic [31:0] ea, el;
    int          wr_cnt, done_cnt;

    bit          ar_hs_n, r_hs_n;
    logic [31:0] ar_addr_n;
    logic [7:0]  ar_len_n;
    bit          ar_hold;
    logic [31:0] held_addr;
    logic [7:0]  held_len;

    bit          stall, bad_rlast;
    int          slverr_beat, tot_beats;
    bit          s_active;
    logic [31:0] s_addr;
    int          s_left, s_idx;

    function automatic logic [31:0] memv(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5EED_0000;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, checks every AR and imem write against the expected queues.
    always @(negedge clk) begin
        ar_hs_n   = reset && m_arvalid && m_arready;
        r_hs_n    = reset && m_rvalid && m_rready;
        ar_addr_n = m_araddr;
        ar_len_n  = m_arlen;
        if (reset) begin
            if (ar_hold)
                chk(m_arvalid && m_araddr == held_addr && m_arlen == held_len, "ar_stable", m_araddr, held_addr);
            ar_hold   = m_arvalid && !m_arready;
            held_addr = m_araddr;
            held_len  = m_arlen;
            if (ar_hs_n) begin
                log_ar_addr.push_back(m_araddr);
                log_ar_len.push_back(32'(m_arlen));
                if (exp_ar_addr.size() == 0) chk(1'b0, "ar_unexpected", m_araddr, 32'h0);
                else begin
                    ea = exp_ar_addr.pop_front();
                    el = exp_ar_len.pop_front();
                    chk(m_araddr == ea, "ar_addr", m_araddr, ea);
                    chk(32'(m_arlen) == el, "ar_len", 32'(m_arlen), el);
                    chk(m_arsize == 3'd2 && m_arburst == 2'b01, "ar_size_burst",
                        32'({m_arsize, m_arburst}), 32'h9);
                end
            end
            if (imem_wr_req || r_hs_n) begin
                chk(imem_wr_req == r_hs_n, "wr_req_vs_beat", 32'(imem_wr_req), 32'(r_hs_n));
                if (imem_wr_req) begin
                    wr_cnt++;
                    if (exp_wr_addr.size() == 0) chk(1'b0, "wr_unexpected", 32'(imem_wr_addr), 32'h0);
                    else begin
                        ea = exp_wr_addr.pop_front();
                        el = exp_wr_data.pop_front();
                        chk(32'(imem_wr_addr) == ea, "wr_addr", 32'(imem_wr_addr), ea);
                        chk(imem_wr_data == el, "wr_data", imem_wr_data, el);
                    end
                end
            end
            if (done) done_cnt++;
        end else begin
            ar_hold = 1'b0;
        end
    end

    // AXI slave: acts on handshakes seen at the previous falling edge, drives new values just after the rising edge.
    initial begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        s_active = 1'b0; s_addr = '0; s_left = 0; s_idx = 0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                s_active = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
                m_rlast = 1'b0; m_rresp = '0; m_rdata = '0;
            end else begin
                if (r_hs_n) begin
                    tot_beats++; s_idx++; s_left--;
                    if (s_left == 0) s_active = 1'b0;
                end
                if (ar_hs_n) begin
                    s_active = 1'b1; s_addr = ar_addr_n; s_left = int'(ar_len_n) + 1; s_idx = 0;
                end
                m_arready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (!s_active) m_rvalid = 1'b0;
                else if (!m_rvalid || r_hs_n) m_rvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (s_active) begin
                    m_rdata = memv(s_addr + 32'(4 * s_idx));
                    m_rlast = bad_rlast ? (s_idx == 0) : (s_left == 1);
                    m_rresp = (tot_beats == slverr_beat - 1) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    task automatic run_fetch(input logic [31:0] b, input int n, input logic [9:0] ib, input bit st,
                             input int serr, input bit badl, input bit inject, input int rst_beat,
                             input int n_ar);
        int rem, len, w4k, idx, k;
        logic [31:0] a;
        bit seen, exp_err;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
        log_ar_addr.delete(); log_ar_len.delete();
        rem = n; a = b; idx = 0;
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            w4k = (4096 - int'(a & 32'hFFF)) / 4;
            if (len > w4k) len = w4k;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(32'(len - 1));
            for (int j = 0; j < len; j++) begin
                exp_wr_addr.push_back(32'((int'(ib) + idx) % 1024));
                exp_wr_data.push_back(memv(a + 32'(4 * j)));
                idx++;
            end
            a = a + 32'(4 * len);
            rem = rem - len;
        end
        exp_err = (serr > 0) || badl;
        stall = st; slverr_beat = serr; bad_rlast = badl;
        tot_beats = 0; wr_cnt = 0; done_cnt = 0;

        @(negedge clk); #1;
        base_addr = b; num_words = 16'(n); imem_base = ib; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", 32'(busy), 32'h1);
        chk(error == 1'b0, "error_cleared_by_start", 32'(error), 32'h0);
        k = 1; seen = 1'b0;
        while (k < 3000 && !seen) begin
            if (done) seen = 1'b1;
            else if (rst_beat > 0 && imem_wr_req && wr_cnt == rst_beat) begin
                reset = 1'b0; #1;
                chk({busy, done, error, imem_wr_req, m_arvalid, m_rready} == 6'b0, "reset_ctrl_zero",
                    32'({busy, done, error, imem_wr_req, m_arvalid, m_rready}), 32'h0);
                chk(m_araddr == 0 && imem_wr_addr == 0 && imem_wr_data == 0 && m_arlen == 0,
                    "reset_regs_zero", m_araddr, 32'h0);
                exp_ar_addr.delete(); exp_ar_len.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
                repeat (3) @(negedge clk);
                #1 reset = 1'b1;
                repeat (6) @(negedge clk);
                #1;
                chk(wr_cnt == rst_beat, "no_writes_after_reset", 32'(wr_cnt), 32'(rst_beat));
                chk(busy == 1'b0, "idle_after_reset", 32'(busy), 32'h0);
                return;
            end else begin
                if (inject && k == 6) begin
                    base_addr = 32'h9000; num_words = 16'd3; imem_base = 10'h200; start = 1'b1;
                end
                if (inject && k == 7) start = 1'b0;
                @(negedge clk); #1;
                k++;
            end
        end
        chk(seen, "done_timeout", 32'(k), 32'd3000);
        if (n == 0) chk(k == 1, "done_latency_zero_words", 32'(k), 32'h1);
        @(negedge clk); #1;
        chk(!done && !busy, "done_one_cycle", 32'({done, busy}), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk(done_cnt == 1, "done_count", 32'(done_cnt), 32'h1);
        chk(error == exp_err, "error_flag", 32'(error), 32'(exp_err));
        chk(wr_cnt == n, "write_count", 32'(wr_cnt), 32'(n));
        chk(log_ar_addr.size() == n_ar, "ar_count", 32'(log_ar_addr.size()), 32'(n_ar));
        chk(exp_ar_addr.size() == 0 && exp_wr_addr.size() == 0, "leftover_expect",
            32'(exp_wr_addr.size()), 32'h0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; imem_base = '0;
        stall = 1'b0; bad_rlast = 1'b0; slverr_beat = 0; tot_beats = 0; wr_cnt = 0; done_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        chk({busy, done, error, imem_wr_req, m_arvalid, m_rready} == 6'b0, "reset_state",
            32'({busy, done, error, imem_wr_req, m_arvalid, m_rready}), 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        run_fetch(32'h1000, 5, 10'h000, 1'b0, 0, 1'b0, 1'b0, 0, 1);
        chk(log_ar_addr.size() > 0 && log_ar_addr[0] == 32'h1000 && log_ar_len[0] == 32'd4,
            "s1_ar", log_ar_len.size() > 0 ? log_ar_len[0] : 32'hFFFF, 32'd4);

        run_fetch(32'h2000, 40, 10'h3F0, 1'b0, 0, 1'b0, 1'b0, 0, 3);
        chk(log_ar_len.size() == 3 && log_ar_len[0] == 15 && log_ar_len[1] == 15 && log_ar_len[2] == 7,
            "s2_arlens", log_ar_len.size() == 3 ? log_ar_len[2] : 32'hFFFF, 32'd7);
        chk(log_ar_addr.size() == 3 && log_ar_addr[1] == 32'h2040 && log_ar_addr[2] == 32'h2080,
            "s2_araddrs", log_ar_addr.size() == 3 ? log_ar_addr[2] : 32'hFFFF, 32'h2080);

        run_fetch(32'h0FF8, 6, 10'h00A, 1'b0, 0, 1'b0, 1'b0, 0, 2);
        chk(log_ar_addr.size() == 2 && log_ar_addr[0] == 32'h0FF8 && log_ar_len[0] == 1 &&
            log_ar_addr[1] == 32'h1000 && log_ar_len[1] == 3,
            "s3_4k_split", log_ar_addr.size() == 2 ? log_ar_addr[1] : 32'hFFFF, 32'h1000);

        run_fetch(32'h1234, 0, 10'h000, 1'b0, 0, 1'b0, 1'b0, 0, 0);

        run_fetch(32'h3000, 4, 10'h020, 1'b1, 2, 1'b0, 1'b0, 0, 1);
        run_fetch(32'h4000, 3, 10'h040, 1'b1, 0, 1'b0, 1'b0, 0, 1);
        run_fetch(32'h4100, 2, 10'h050, 1'b0, 0, 1'b1, 1'b0, 0, 1);
        run_fetch(32'h5000, 20, 10'h100, 1'b0, 0, 1'b0, 1'b1, 0, 2);
        run_fetch(32'h7000, 16, 10'h000, 1'b0, 0, 1'b0, 1'b0, 3, 1);
        run_fetch(32'h8000, 3, 10'h300, 1'b1, 0, 1'b0, 1'b0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
